// File: rtl/ip_pkg.sv
// ip_pkg: IPv4 header constants, encapsulator FSM encoding and final-word keep helper.
// Rev 1.0
`default_nettype none

package ip_pkg;

    localparam logic [3:0] IP_VERSION   = 4'd4;
    localparam logic [3:0] IP_IHL       = 4'd5;
    localparam int         IP_HDR_WORDS = 5;
    localparam logic [7:0] IP_PROTO_TCP = 8'h06;
    localparam logic [7:0] IP_PROTO_UDP = 8'h11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CSUM    = 2'd1,
        ST_HDR     = 2'd2,
        ST_PAYLOAD = 2'd3
    } ip_state_t;

    // Byte enables for the final payload word from the residue of the byte length.
    function automatic logic [3:0] keep_for_len(input logic [1:0] len_lsb);
        case (len_lsb)
            2'd1:    keep_for_len = 4'h8;
            2'd2:    keep_for_len = 4'hC;
            2'd3:    keep_for_len = 4'hE;
            default: keep_for_len = 4'hF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ipv4_csum.sv
// ipv4_csum: combinational IPv4 header checksum over ten 16-bit words.
// Rev 1.0
`default_nettype none

module ipv4_csum (
    input  logic [159:0] i_hdr,
    output logic [15:0]  o_csum
);

    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [16:0] w_fold2;

    always_comb begin
        w_sum = 20'd0;
        for (int i = 0; i < 10; i++) begin
            w_sum = w_sum + {4'd0, i_hdr[i*16 +: 16]};
        end
    end

    // Two folds are enough: the first can leave at most a single carry.
    assign w_fold1 = {1'b0, w_sum[15:0]} + {13'd0, w_sum[19:16]};
    assign w_fold2 = {1'b0, w_fold1[15:0]} + {16'd0, w_fold1[16]};
    assign o_csum  = ~w_fold2[15:0];

endmodule

`default_nettype wire

// File: rtl/ip_tx_encap.sv
// ip_tx_encap: IPv4 transmit encapsulator, descriptor in, header + payload words out.
// Rev 1.0
`default_nettype none

module ip_tx_encap
    import ip_pkg::*;
#(
    parameter logic [7:0]  IP_TTL      = 8'h40,
    parameter logic [7:0]  IP_TOS      = 8'h00,
    parameter logic        IP_DF       = 1'b1,
    parameter logic [15:0] ID_INIT     = 16'h0000,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cfg_src_ip,
    input  logic [31:0] cfg_dst_ip,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [15:0] desc_len,
    input  logic [7:0]  desc_proto,
    output logic        desc_err,
    input  logic [31:0] tcp_tx_data,
    input  logic        tcp_tx_valid,
    output logic        tcp_tx_ready,
    input  logic        tcp_tx_last,
    output logic [31:0] eth_tx_data,
    output logic        eth_tx_valid,
    input  logic        eth_tx_ready,
    output logic        eth_tx_last,
    output logic [3:0]  eth_tx_keep,
    output logic        len_mismatch
);

    localparam logic [15:0] c_FLAGS_FRAG = IP_DF ? 16'h4000 : 16'h0000;
    localparam logic [2:0]  c_HDR_LAST   = 3'(IP_HDR_WORDS - 1);

    ip_state_t   r_state;
    ip_state_t   w_next;
    logic [15:0] r_len;
    logic [7:0]  r_proto;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [15:0] r_csum;
    logic [15:0] r_id;
    logic [2:0]  r_hcnt;
    logic [15:0] r_wrem;
    logic        r_desc_ready;
    logic        r_desc_err;
    logic        r_len_mismatch;

    logic        w_desc_acc;
    logic        w_len_bad;
    logic        w_eth_hs;
    logic        w_hdr_last;
    logic        w_pay_final;
    logic        w_len_zero;
    logic [15:0] w_total_len;
    logic [16:0] w_nwords;
    logic [15:0] w_csum;
    logic [31:0] w_hdr_word;

    assign w_desc_acc  = desc_valid && r_desc_ready;
    assign w_len_bad   = desc_len > MAX_PAYLOAD;
    assign w_eth_hs    = eth_tx_valid && eth_tx_ready;
    assign w_hdr_last  = (r_hcnt == c_HDR_LAST);
    assign w_pay_final = (r_wrem == 16'd0);
    assign w_len_zero  = (r_len == 16'd0);
    assign w_total_len = r_len + 16'd20;
    assign w_nwords    = ({1'b0, r_len} + 17'd3) >> 2;

    ipv4_csum u_csum (
        .i_hdr  ({IP_VERSION, IP_IHL, IP_TOS, w_total_len,
                  r_id, c_FLAGS_FRAG,
                  IP_TTL, r_proto, 16'h0000,
                  r_src, r_dst}),
        .o_csum (w_csum)
    );

    always_comb begin
        case (r_hcnt)
            3'd0:    w_hdr_word = {IP_VERSION, IP_IHL, IP_TOS, w_total_len};
            3'd1:    w_hdr_word = {r_id, c_FLAGS_FRAG};
            3'd2:    w_hdr_word = {IP_TTL, r_proto, r_csum};
            3'd3:    w_hdr_word = r_src;
            default: w_hdr_word = r_dst;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_desc_acc && !w_len_bad) w_next = ST_CSUM;
            ST_CSUM:    w_next = ST_HDR;
            ST_HDR:     if (w_eth_hs && w_hdr_last) w_next = w_len_zero ? ST_IDLE : ST_PAYLOAD;
            ST_PAYLOAD: if (w_eth_hs && w_pay_final) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        eth_tx_valid = 1'b0;
        eth_tx_data  = 32'd0;
        eth_tx_last  = 1'b0;
        eth_tx_keep  = 4'h0;
        tcp_tx_ready = 1'b0;
        case (r_state)
            ST_HDR: begin
                eth_tx_valid = 1'b1;
                eth_tx_data  = w_hdr_word;
                eth_tx_last  = w_hdr_last && w_len_zero;
                eth_tx_keep  = 4'hF;
            end
            ST_PAYLOAD: begin
                eth_tx_valid = tcp_tx_valid;
                eth_tx_data  = tcp_tx_data;
                eth_tx_last  = w_pay_final;
                eth_tx_keep  = w_pay_final ? keep_for_len(r_len[1:0]) : 4'hF;
                tcp_tx_ready = eth_tx_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len          <= 16'd0;
            r_proto        <= 8'd0;
            r_src          <= 32'd0;
            r_dst          <= 32'd0;
            r_csum         <= 16'd0;
            r_id           <= ID_INIT;
            r_hcnt         <= 3'd0;
            r_wrem         <= 16'd0;
            r_desc_ready   <= 1'b0;
            r_desc_err     <= 1'b0;
            r_len_mismatch <= 1'b0;
        end else begin
            r_desc_ready   <= (w_next == ST_IDLE);
            r_desc_err     <= (r_state == ST_IDLE) && w_desc_acc && w_len_bad;
            r_len_mismatch <= (r_state == ST_PAYLOAD) && w_eth_hs && (tcp_tx_last != w_pay_final);
            if ((r_state == ST_IDLE) && w_desc_acc && !w_len_bad) begin
                r_len   <= desc_len;
                r_proto <= desc_proto;
                r_src   <= cfg_src_ip;
                r_dst   <= cfg_dst_ip;
            end
            if (r_state == ST_CSUM) begin
                r_csum <= w_csum;
                r_hcnt <= 3'd0;
                r_wrem <= w_nwords[15:0] - 16'd1;
            end
            if ((r_state == ST_HDR) && w_eth_hs && !w_hdr_last) begin
                r_hcnt <= r_hcnt + 3'd1;
            end
            if ((r_state == ST_PAYLOAD) && w_eth_hs && !w_pay_final) begin
                r_wrem <= r_wrem - 16'd1;
            end
            if (w_eth_hs && eth_tx_last) begin
                r_id <= r_id + 16'd1;
            end
        end
    end

    assign desc_ready   = r_desc_ready;
    assign desc_err     = r_desc_err;
    assign len_mismatch = r_len_mismatch;

endmodule

`default_nettype wire

// File: tb/tb_ip_tx_encap.sv
// tb_ip_tx_encap: scoreboard bench for ip_tx_encap with directed packets.
// Rev 1.0
`default_nettype none

module tb_ip_tx_encap;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  keep;
    } beat_t;

    localparam logic [31:0] c_SRC = 32'hC0A80001;
    localparam logic [31:0] c_DST = 32'hC0A80002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_src_ip = c_SRC;
    logic [31:0] cfg_dst_ip = c_DST;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [15:0] desc_len = 16'd0;
    logic [7:0]  desc_proto = 8'h06;
    logic        desc_err;
    logic [31:0] tcp_tx_data = 32'd0;
    logic        tcp_tx_valid = 1'b0;
    logic        tcp_tx_ready;
    logic        tcp_tx_last = 1'b0;
    logic [31:0] eth_tx_data;
    logic        eth_tx_valid;
    logic        eth_tx_ready = 1'b1;
    logic        eth_tx_last;
    logic [3:0]  eth_tx_keep;
    logic        len_mismatch;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    bit    rand_ready = 1'b0;
    int    n_desc_err = 0;
    int    n_mismatch = 0;
    int    n_tcp_ready = 0;
    int    n_valid = 0;

    ip_tx_encap dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_src_ip   (cfg_src_ip),
        .cfg_dst_ip   (cfg_dst_ip),
        .desc_valid   (desc_valid),
        .desc_ready   (desc_ready),
        .desc_len     (desc_len),
        .desc_proto   (desc_proto),
        .desc_err     (desc_err),
        .tcp_tx_data  (tcp_tx_data),
        .tcp_tx_valid (tcp_tx_valid),
        .tcp_tx_ready (tcp_tx_ready),
        .tcp_tx_last  (tcp_tx_last),
        .eth_tx_data  (eth_tx_data),
        .eth_tx_valid (eth_tx_valid),
        .eth_tx_ready (eth_tx_ready),
        .eth_tx_last  (eth_tx_last),
        .eth_tx_keep  (eth_tx_keep),
        .len_mismatch (len_mismatch)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time=%0t required=<2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1 eth_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold-while-stalled.
    beat_t prev_beat;
    bit    prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (desc_err)     n_desc_err++;
            if (len_mismatch) n_mismatch++;
            if (tcp_tx_ready) n_tcp_ready++;
            if (eth_tx_valid) n_valid++;
            if (prev_stall) begin
                chk("stall_valid", {31'd0, eth_tx_valid}, 32'd1);
                chk("stall_hold", {eth_tx_data[26:0], eth_tx_last, eth_tx_keep},
                    {prev_beat.data[26:0], prev_beat.last, prev_beat.keep});
            end
            if (eth_tx_valid && eth_tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got %08h expected none", eth_tx_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", eth_tx_data, e.data);
                    chk("beat_last_keep", {27'd0, eth_tx_last, eth_tx_keep}, {27'd0, e.last, e.keep});
                end
            end
            prev_stall = eth_tx_valid && !eth_tx_ready;
            prev_beat  = '{data: eth_tx_data, last: eth_tx_last, keep: eth_tx_keep};
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [3:0] exp_keep(input logic [15:0] len);
        case (len % 4)
            0:       return 4'hF;
            1:       return 4'h8;
            2:       return 4'hC;
            default: return 4'hE;
        endcase
    endfunction

    function automatic logic [31:0] pay_word(input logic [31:0] base, input int i);
        return base + 32'(i) * 32'h01010101;
    endfunction

    task automatic push(input logic [31:0] d, input logic l, input logic [3:0] k);
        exp_q.push_back('{data: d, last: l, keep: k});
    endtask

    // Reference header model: builds words and checksum from first principles.
    task automatic push_hdr(input logic [15:0] len, input logic [15:0] id);
        logic [15:0] h[10];
        int unsigned s;
        logic [15:0] cs;
        h[0] = 16'h4500; h[1] = len + 16'd20; h[2] = id; h[3] = 16'h4000;
        h[4] = 16'h4006; h[5] = 16'h0000;
        h[6] = c_SRC[31:16]; h[7] = c_SRC[15:0]; h[8] = c_DST[31:16]; h[9] = c_DST[15:0];
        s = 0;
        for (int i = 0; i < 10; i++) s += h[i];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        push({h[0], h[1]}, 1'b0, 4'hF);
        push({h[2], h[3]}, 1'b0, 4'hF);
        push({h[4], cs}, 1'b0, 4'hF);
        push(c_SRC, 1'b0, 4'hF);
        push(c_DST, len == 16'd0, 4'hF);
    endtask

    task automatic send_desc(input logic [15:0] len);
        int t = 0;
        bit acc = 1'b0;
        desc_len   = len;
        desc_proto = 8'h06;
        desc_valid = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = desc_ready;
            @(posedge clk);
            #1 t++;
        end
        desc_valid = 1'b0;
        if (!acc) chk("desc_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive_word(input logic [31:0] d, input logic l);
        int t = 0;
        bit hs = 1'b0;
        tcp_tx_data  = d;
        tcp_tx_last  = l;
        tcp_tx_valid = 1'b1;
        while (!hs && t < 400) begin
            @(negedge clk);
            hs = tcp_tx_ready;
            @(posedge clk);
            #1 t++;
        end
        tcp_tx_valid = 1'b0;
        tcp_tx_last  = 1'b0;
        if (!hs) chk("tcp_hs_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1 t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Pushes expected payload beats, sends descriptor, drives payload, waits for drain.
    task automatic run_pkt(input logic [15:0] len, input logic [31:0] base, input int early_idx);
        int nw;
        nw = (int'(len) + 3) / 4;
        for (int i = 0; i < nw; i++)
            push(pay_word(base, i), i == nw - 1, (i == nw - 1) ? exp_keep(len) : 4'hF);
        send_desc(len);
        for (int i = 0; i < nw; i++)
            drive_word(pay_word(base, i), (i == nw - 1) || (i == early_idx));
        wait_drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {desc_ready, desc_err, tcp_tx_ready, eth_tx_valid, eth_tx_last,
                            len_mismatch, eth_tx_keep}, 32'd0);
        chk("rst_data", eth_tx_data, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: len=8, ID=0
        push(32'h4500001C, 1'b0, 4'hF);
        push(32'h00004000, 1'b0, 4'hF);
        push(32'h4006B988, 1'b0, 4'hF);
        push(32'hC0A80001, 1'b0, 4'hF);
        push(32'hC0A80002, 1'b0, 4'hF);
        run_pkt(16'd8, 32'h11223344, -1);

        // 2: len=5, ID=1
        push(32'h45000019, 1'b0, 4'hF);
        push(32'h00014000, 1'b0, 4'hF);
        push(32'h4006B98A, 1'b0, 4'hF);
        push(32'hC0A80001, 1'b0, 4'hF);
        push(32'hC0A80002, 1'b0, 4'hF);
        run_pkt(16'd5, 32'hA0B0C0D0, -1);

        // 3: len=0, ID=2, header only
        n_tcp_ready = 0;
        push(32'h45000014, 1'b0, 4'hF);
        push(32'h00024000, 1'b0, 4'hF);
        push(32'h4006B98E, 1'b0, 4'hF);
        push(32'hC0A80001, 1'b0, 4'hF);
        push(32'hC0A80002, 1'b1, 4'hF);
        run_pkt(16'd0, 32'h0, -1);
        chk("len0_tcp_ready_cycles", n_tcp_ready, 32'd0);

        // 4: random backpressure, len=10, ID=3
        rand_ready = 1'b1;
        push_hdr(16'd10, 16'd3);
        run_pkt(16'd10, 32'h5A000001, -1);
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 5a: oversize descriptor rejected
        n_desc_err = 0;
        n_valid    = 0;
        send_desc(16'd1481);
        repeat (5) @(posedge clk);
        #1;
        chk("reject_desc_err_pulses", n_desc_err, 32'd1);
        chk("reject_no_valid", n_valid, 32'd0);
        chk("reject_ready_again", {31'd0, desc_ready}, 32'd1);

        // 5b: early tcp_tx_last on word 1, ID still 4
        n_mismatch = 0;
        push_hdr(16'd12, 16'd4);
        run_pkt(16'd12, 32'h77000000, 1);
        chk("early_last_mismatch_pulses", n_mismatch, 32'd1);

        // 6: reset mid-payload
        push_hdr(16'd8, 16'd5);
        push(pay_word(32'h33000000, 0), 1'b0, 4'hF);
        push(pay_word(32'h33000000, 1), 1'b1, 4'hF);
        send_desc(16'd8);
        drive_word(pay_word(32'h33000000, 0), 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {desc_ready, desc_err, tcp_tx_ready, eth_tx_valid, eth_tx_last,
                               len_mismatch, eth_tx_keep}, 32'd0);
        chk("midrst_data", eth_tx_data, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;

        push_hdr(16'd4, 16'd0);
        run_pkt(16'd4, 32'h44556677, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
